// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, access sizes and FSM encoding for the MEM-stage load/store unit.
package mem_lsu_pkg;

    // EX-stage memory op codes
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_lane.sv
// Pure combinational lane logic: op decode, alignment, byte enables,
// store-data replication and load extraction/extension (big-endian lanes).
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_rdata,
    output logic        o_is_mem,
    output logic        o_is_load,
    output logic        o_misal,
    output logic [3:0]  o_sel,
    output logic [31:0] o_sdata,
    output logic [31:0] o_ldata
);

    lsu_size_e   w_size;
    logic        w_signed;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decode op into memory/load flags, access size and signedness
    always_comb begin
        o_is_mem  = 1'b1;
        o_is_load = 1'b1;
        w_size    = SZ_WORD;
        w_signed  = 1'b0;
        case (i_op)
            EXE_LB_OP:  begin w_size = SZ_BYTE; w_signed = 1'b1; end
            EXE_LBU_OP: w_size = SZ_BYTE;
            EXE_LH_OP:  begin w_size = SZ_HALF; w_signed = 1'b1; end
            EXE_LHU_OP: w_size = SZ_HALF;
            EXE_LW_OP:  w_size = SZ_WORD;
            EXE_SB_OP:  begin w_size = SZ_BYTE; o_is_load = 1'b0; end
            EXE_SH_OP:  begin w_size = SZ_HALF; o_is_load = 1'b0; end
            EXE_SW_OP:  o_is_load = 1'b0;
            default:    begin o_is_mem = 1'b0; o_is_load = 1'b0; end
        endcase
    end

    // Byte enables, replicated store data and alignment check per size
    always_comb begin
        o_sel   = 4'b1111;
        o_sdata = i_rt;
        o_misal = 1'b0;
        case (w_size)
            SZ_BYTE: begin
                o_sel   = 4'b1000 >> i_off;
                o_sdata = {4{i_rt[7:0]}};
            end
            SZ_HALF: begin
                o_sel   = i_off[1] ? 4'b0011 : 4'b1100;
                o_sdata = {2{i_rt[15:0]}};
                o_misal = i_off[0];
            end
            default: o_misal = |i_off;
        endcase
        if (!o_is_mem) o_misal = 1'b0;
    end

    // Pick the addressed byte/half (byte 0 lives in bits 31:24) and extend it
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
        case (w_size)
            SZ_BYTE: o_ldata = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_ldata = {{16{w_signed & w_half[15]}}, w_half};
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE req/ack bus FSM with ack timeout,
// stall request while an access is outstanding, and load writeback merge.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    lsu_state_e  r_state, w_next;
    logic [31:0] r_timer;
    logic        r_req, r_we, r_bus_err;
    logic [31:0] r_addr, r_data, r_rdata;
    logic [3:0]  r_sel;

    logic        w_is_mem, w_is_load, w_misal, w_timeout;
    logic [3:0]  w_sel;
    logic [31:0] w_sdata, w_ldata;

    // Inputs are held by the stall for the whole access, so the live op
    // drives both request formatting and DONE-cycle load extension.
    mem_lsu_lane u_lane (
        .i_op      (aluop_i),
        .i_off     (mem_addr_i[1:0]),
        .i_rt      (reg2_i),
        .i_rdata   (r_rdata),
        .o_is_mem  (w_is_mem),
        .o_is_load (w_is_load),
        .o_misal   (w_misal),
        .o_sel     (w_sel),
        .o_sdata   (w_sdata),
        .o_ldata   (w_ldata)
    );

    // Timer reaches the limit on the last allowed BUSY cycle
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TIMEOUT_CYCLES - 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; ack takes priority over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_is_mem && !w_misal) w_next = ST_BUSY;
            ST_BUSY: if (mem_ack_i || w_timeout) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Bus request registers, wait timer, read-data capture and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_timer   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_next == ST_BUSY) begin
                    r_req   <= 1'b1;
                    r_we    <= ~w_is_load;
                    r_addr  <= {mem_addr_i[31:2], 2'b00};
                    r_sel   <= w_sel;
                    r_data  <= w_sdata;
                    r_timer <= '0;
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        r_rdata <= mem_data_i;
                        r_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Writeback/stall outputs; r_bus_err doubles as the timed-out flag in DONE
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        case (r_state)
            ST_IDLE: if (w_is_mem) begin
                wreg_o = 1'b0;
                if (w_misal) align_err_o = 1'b1;
                else         stallreq_o  = 1'b1;
            end
            ST_BUSY: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
            end
            default: begin
                if (r_bus_err)      wreg_o  = 1'b0;
                else if (w_is_load) wdata_o = w_ldata;
            end
        endcase
    end

    assign bus_err_o  = r_bus_err;
    assign mem_req_o  = r_req;
    assign mem_we_o   = r_we;
    assign mem_addr_o = r_addr;
    assign mem_sel_o  = r_sel;
    assign mem_data_o = r_data;

endmodule
